// File: rtl/ct_had_tap_pkg.sv
// Shared TAP definitions: state encoding, opcodes, IR capture pattern, next-state helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package ct_had_tap_pkg;

  // Classic 1149.1 4-bit state encoding
  typedef enum logic [3:0] {
    TAP_EXIT2_DR   = 4'h0,
    TAP_EXIT1_DR   = 4'h1,
    TAP_SHIFT_DR   = 4'h2,
    TAP_PAUSE_DR   = 4'h3,
    TAP_SEL_IR     = 4'h4,
    TAP_UPDATE_DR  = 4'h5,
    TAP_CAPTURE_DR = 4'h6,
    TAP_SEL_DR     = 4'h7,
    TAP_EXIT2_IR   = 4'h8,
    TAP_EXIT1_IR   = 4'h9,
    TAP_SHIFT_IR   = 4'hA,
    TAP_PAUSE_IR   = 4'hB,
    TAP_RTI        = 4'hC,
    TAP_UPDATE_IR  = 4'hD,
    TAP_CAPTURE_IR = 4'hE,
    TAP_TLR        = 4'hF
  } tap_state_e;

  localparam logic [4:0] OPC_IDCODE    = 5'h01;
  localparam logic [4:0] OPC_DR_ACCESS = 5'h11;
  localparam logic [4:0] OPC_BYPASS    = 5'h1F;

  // Two LSBs loaded into the IR shifter in CAPTURE_IR; upper bits are zero
  localparam logic [1:0] IR_CAPTURE_PAT = 2'b01;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    case (s)
      TAP_TLR:        tap_next = tms ? TAP_TLR       : TAP_RTI;
      TAP_RTI:        tap_next = tms ? TAP_SEL_DR    : TAP_RTI;
      TAP_SEL_DR:     tap_next = tms ? TAP_SEL_IR    : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR: tap_next = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_SHIFT_DR:   tap_next = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_EXIT1_DR:   tap_next = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:   tap_next = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
      TAP_EXIT2_DR:   tap_next = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR:  tap_next = tms ? TAP_SEL_DR    : TAP_RTI;
      TAP_SEL_IR:     tap_next = tms ? TAP_TLR       : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR: tap_next = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_SHIFT_IR:   tap_next = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_EXIT1_IR:   tap_next = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:   tap_next = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
      TAP_EXIT2_IR:   tap_next = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR:  tap_next = tms ? TAP_SEL_DR    : TAP_RTI;
      default:        tap_next = TAP_TLR;
    endcase
  endfunction

endpackage

// File: rtl/ct_had_tap_fsm.sv
// TAP controller state register plus one-hot decodes of current/next state.
// Latency: one state transition per tclk rising edge; decodes are straight off the state flops.
// Backpressure: none; io_sm_tap_en low forces TEST_LOGIC_RESET regardless of TMS.
module ct_had_tap_fsm
  import ct_had_tap_pkg::*;
(
  input  logic tclk,
  input  logic trst,
  input  logic tms,
  input  logic tap_en,
  output logic st_tlr,
  output logic st_capture_ir,
  output logic st_shift_ir,
  output logic st_update_ir,
  output logic st_capture_dr,
  output logic st_shift_dr,
  output logic st_ir_path,
  output logic nxt_shift,
  output logic nxt_update_dr
);

  tap_state_e state;
  tap_state_e state_nxt;

  // Next state: disabled port parks the controller in reset
  always_comb begin
    state_nxt = tap_en ? tap_next(state, tms) : TAP_TLR;
  end

  // State register
  always_ff @(posedge tclk or posedge trst) begin
    if (trst) state <= TAP_TLR;
    else      state <= state_nxt;
  end

  assign st_tlr        = (state == TAP_TLR);
  assign st_capture_ir = (state == TAP_CAPTURE_IR);
  assign st_shift_ir   = (state == TAP_SHIFT_IR);
  assign st_update_ir  = (state == TAP_UPDATE_IR);
  assign st_capture_dr = (state == TAP_CAPTURE_DR);
  assign st_shift_dr   = (state == TAP_SHIFT_DR);
  assign st_ir_path    = state inside {TAP_CAPTURE_IR, TAP_SHIFT_IR, TAP_EXIT1_IR,
                                       TAP_PAUSE_IR, TAP_EXIT2_IR, TAP_UPDATE_IR};
  // Look-ahead decodes so the tdo_en / update flops line up with the state itself
  assign nxt_shift     = state_nxt inside {TAP_SHIFT_IR, TAP_SHIFT_DR};
  assign nxt_update_dr = (state_nxt == TAP_UPDATE_DR);

endmodule

// File: rtl/ct_had_jtag_tap.sv
// HAD debug TAP: IR / BYPASS / IDCODE / DR_ACCESS shift paths behind the pad stage.
// Latency: serial, one bit per tclk; update strobe registered, high for the UPDATE_DR cycle only.
// Backpressure: none; TCK-paced. Optional IDCODE register under `HAD_TAP_IDCODE_EN.
module ct_had_jtag_tap
  import ct_had_tap_pkg::*;
#(
  parameter int          IR_W   = 5,
  parameter int          DR_W   = 32,
  parameter logic [31:0] IDCODE = 32'h1000_0B6F
) (
  input  logic            tclk,
  input  logic            trst,
  input  logic            pad_had_jtg_tms,
  input  logic            io_serial_tdi,
  input  logic            io_sm_tap_en,
  input  logic [DR_W-1:0] tap_dr_capture_data,
  output logic            serial_io_tdo,
  output logic            sm_io_tdo_en,
  output logic [DR_W-1:0] tap_dr_data,
  output logic            tap_dr_update,
  output logic [IR_W-1:0] tap_ir
);

  // Elaboration-time sanity on the parameters
  if (IR_W < 2 || IDCODE[0] != 1'b1) begin : g_param_chk
    $error("ct_had_jtag_tap: IR_W must be >= 2 and IDCODE[0] must be 1");
  end

  localparam logic [IR_W-1:0] IR_DR_ACCESS = IR_W'(OPC_DR_ACCESS);
  localparam logic [IR_W-1:0] IR_BYPASS    = IR_W'(OPC_BYPASS);
`ifdef HAD_TAP_IDCODE_EN
  localparam logic [IR_W-1:0] IR_IDCODE    = IR_W'(OPC_IDCODE);
  localparam logic [IR_W-1:0] IR_RST       = IR_IDCODE;
`else
  localparam logic [IR_W-1:0] IR_RST       = IR_BYPASS;
`endif

  logic st_tlr, st_capture_ir, st_shift_ir, st_update_ir;
  logic st_capture_dr, st_shift_dr, st_ir_path, nxt_shift, nxt_update_dr;

  logic [IR_W-1:0] ir;
  logic [IR_W-1:0] ir_sh;
  logic            bypass_sh;
  logic [DR_W-1:0] dr_sh;
  logic            sel_dr_access;
  logic            sel_idcode;
  logic            sel_bypass;
  logic            tdo_mux;
  logic            tdo_en_q;
  logic            dr_update_q;

  ct_had_tap_fsm u_fsm (
    .tclk          (tclk),
    .trst          (trst),
    .tms           (pad_had_jtg_tms),
    .tap_en        (io_sm_tap_en),
    .st_tlr        (st_tlr),
    .st_capture_ir (st_capture_ir),
    .st_shift_ir   (st_shift_ir),
    .st_update_ir  (st_update_ir),
    .st_capture_dr (st_capture_dr),
    .st_shift_dr   (st_shift_dr),
    .st_ir_path    (st_ir_path),
    .nxt_shift     (nxt_shift),
    .nxt_update_dr (nxt_update_dr)
  );

  // Register selection; unknown opcodes fall through to BYPASS
  assign sel_dr_access = (ir == IR_DR_ACCESS);
`ifdef HAD_TAP_IDCODE_EN
  assign sel_idcode    = (ir == IR_IDCODE);
`else
  assign sel_idcode    = 1'b0;
`endif
  assign sel_bypass    = !sel_dr_access && !sel_idcode;

  // Instruction register and its shifter; sitting in TLR re-arms the reset opcode
  always_ff @(posedge tclk or posedge trst) begin
    if (trst) begin
      ir    <= IR_RST;
      ir_sh <= '0;
    end else begin
      if (st_tlr)            ir <= IR_RST;
      else if (st_update_ir) ir <= ir_sh;
      if (st_capture_ir)     ir_sh <= IR_W'(IR_CAPTURE_PAT);
      else if (st_shift_ir)  ir_sh <= {io_serial_tdi, ir_sh[IR_W-1:1]};
    end
  end

  // BYPASS: single flop, zero on capture, then a one-cycle TDI delay
  always_ff @(posedge tclk or posedge trst) begin
    if (trst)                          bypass_sh <= 1'b0;
    else if (sel_bypass && st_capture_dr) bypass_sh <= 1'b0;
    else if (sel_bypass && st_shift_dr)   bypass_sh <= io_serial_tdi;
  end

  // DR_ACCESS shifter; the shift form also covers DR_W == 1.
  // Held in every state other than CAPTURE_DR / SHIFT_DR, including PAUSE.
  always_ff @(posedge tclk or posedge trst) begin
    if (trst)                                dr_sh <= '0;
    else if (sel_dr_access && st_capture_dr) dr_sh <= tap_dr_capture_data;
    else if (sel_dr_access && st_shift_dr)   dr_sh <= DR_W'({io_serial_tdi, dr_sh} >> 1);
  end

`ifdef HAD_TAP_IDCODE_EN
  logic [31:0] idcode_sh;

  // IDCODE shifter
  always_ff @(posedge tclk or posedge trst) begin
    if (trst)                             idcode_sh <= '0;
    else if (sel_idcode && st_capture_dr) idcode_sh <= IDCODE;
    else if (sel_idcode && st_shift_dr)   idcode_sh <= {io_serial_tdi, idcode_sh[31:1]};
  end
`endif

  // TDO mux: purely from flops, so no TDI-to-TDO combinational path
  always_comb begin
    tdo_mux = bypass_sh;
    if (st_ir_path)         tdo_mux = ir_sh[0];
    else if (sel_dr_access) tdo_mux = dr_sh[0];
`ifdef HAD_TAP_IDCODE_EN
    else if (sel_idcode)    tdo_mux = idcode_sh[0];
`endif
  end

  // Output enable and update strobe, registered off the next-state decode
  always_ff @(posedge tclk or posedge trst) begin
    if (trst) begin
      tdo_en_q    <= 1'b0;
      dr_update_q <= 1'b0;
    end else begin
      tdo_en_q    <= nxt_shift;
      dr_update_q <= nxt_update_dr && sel_dr_access;
    end
  end

  assign serial_io_tdo = tdo_mux;
  assign sm_io_tdo_en  = tdo_en_q;
  assign tap_dr_data   = dr_sh;
  assign tap_dr_update = dr_update_q;
  assign tap_ir        = ir;

endmodule

// File: tb/tb_ct_had_jtag_tap.sv
// Directed bench for ct_had_jtag_tap with a queue-based scoreboard on TDO and update strobes.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench); honours `HAD_TAP_IDCODE_EN for the reset-opcode expectations.
module tb_ct_had_jtag_tap;

`ifdef HAD_TAP_IDCODE_EN
  localparam logic [4:0]  IR_RST_EXP = 5'h01;
  localparam logic [31:0] T1_EXP     = 32'h1000_0B6F;
`else
  localparam logic [4:0]  IR_RST_EXP = 5'h1F;
  localparam logic [31:0] T1_EXP     = 32'hBD5B_7DDE;  // bypass of DEADBEEF: 0 then tdi delayed
`endif

  logic        tclk = 1'b0;
  logic        trst;
  logic        tms;
  logic        tdi;
  logic        tap_en;
  logic [31:0] cap_data;
  logic        tdo;
  logic        tdo_en;
  logic [31:0] dr_data;
  logic        dr_upd;
  logic [4:0]  ir;

  logic        exp_tdo_q[$];
  logic [31:0] exp_upd_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  ct_had_jtag_tap dut (
    .tclk                (tclk),
    .trst                (trst),
    .pad_had_jtg_tms     (tms),
    .io_serial_tdi       (tdi),
    .io_sm_tap_en        (tap_en),
    .tap_dr_capture_data (cap_data),
    .serial_io_tdo       (tdo),
    .sm_io_tdo_en        (tdo_en),
    .tap_dr_data         (dr_data),
    .tap_dr_update       (dr_upd),
    .tap_ir              (ir)
  );

  always #5 tclk = ~tclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a TDO bit or an update strobe
  always @(negedge tclk) begin
    if (tdo_en === 1'b1) begin
      if (exp_tdo_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL tdo_en_unexpected: got tdo_en=1 expected no shift at %0t", $time);
      end else begin
        chk("tdo_bit", {63'd0, tdo}, {63'd0, exp_tdo_q.pop_front()});
      end
    end
    if (dr_upd === 1'b1) begin
      if (exp_upd_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL update_unexpected: got tap_dr_update=1 expected 0 at %0t", $time);
      end else begin
        chk("update_data", {32'd0, dr_data}, {32'd0, exp_upd_q.pop_front()});
      end
    end
  end

  task automatic step(input logic t, input logic d);
    @(negedge tclk);
    tms = t;
    tdi = d;
    @(posedge tclk);
    #1;
  endtask

  // From RTI: shift an opcode in; the captured 5'b00001 comes out LSB first
  task automatic load_ir(input logic [4:0] op);
    exp_tdo_q.push_back(1'b1);
    for (int i = 1; i < 5; i++) exp_tdo_q.push_back(1'b0);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 5; i++) step(i == 4, op[i]);
    step(1, 0); step(0, 0);
    chk("tap_ir_load", {59'd0, ir}, {59'd0, op});
  endtask

  // From RTI: n-bit DR scan, optional pause after bit pause_at-1, back to RTI
  task automatic shift_dr(input int n, input logic [31:0] din, input logic [31:0] dout,
                          input bit upd, input int pause_at);
    for (int i = 0; i < n; i++) exp_tdo_q.push_back(dout[i]);
    if (upd) exp_upd_q.push_back(din);
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < n; i++) begin
      step((i == n - 1) || (i == pause_at - 1), din[i]);
      if (i == pause_at - 1 && i != n - 1) begin
        step(0, 0); step(0, 0); step(1, 0); step(0, 0);
      end
    end
    step(1, 0); step(0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    trst = 1'b1; tap_en = 1'b1; tms = 1'b1; tdi = 1'b0; cap_data = '0;
    #12;
    chk("rst_ir",     {59'd0, ir},      {59'd0, IR_RST_EXP});
    chk("rst_tdo",    {63'd0, tdo},     64'd0);
    chk("rst_tdo_en", {63'd0, tdo_en},  64'd0);
    chk("rst_update", {63'd0, dr_upd},  64'd0);
    chk("rst_dr",     {32'd0, dr_data}, 64'd0);
    trst = 1'b0;

    // Reset-opcode DR read (IDCODE, or bypass without it)
    repeat (5) step(1, 0);
    step(0, 0);
    shift_dr(32, 32'hDEAD_BEEF, T1_EXP, 1'b0, 0);

    // DR_ACCESS with a pause mid-scan
    cap_data = 32'hA5A5_0F0F;
    load_ir(5'h11);
    shift_dr(32, 32'h1234_5678, 32'hA5A5_0F0F, 1'b1, 16);
    chk("dr_after_update", {32'd0, dr_data}, {32'd0, 32'h1234_5678});

    // Zero-length DR scan still updates with the captured value
    cap_data = 32'h0BAD_F00D;
    exp_upd_q.push_back(32'h0BAD_F00D);
    step(1, 0); step(0, 0); step(1, 0); step(1, 0); step(0, 0);
    chk("dr_zero_shift", {32'd0, dr_data}, {32'd0, 32'h0BAD_F00D});

    // BYPASS: 0 then tdi delayed one cycle, no strobe, DR_ACCESS untouched
    load_ir(5'h1F);
    shift_dr(8, 32'h0000_00C3, 32'h0000_0086, 1'b0, 0);
    chk("dr_hold_bypass", {32'd0, dr_data}, {32'd0, 32'h0BAD_F00D});

    // Unknown opcode behaves as BYPASS
    load_ir(5'h07);
    shift_dr(4, 32'h0000_000A, 32'h0000_0004, 1'b0, 0);

    // Zero-length IR scan loads the capture pattern
    step(1, 0); step(1, 0); step(0, 0); step(1, 0); step(1, 0); step(0, 0);
    chk("ir_zero_shift", {59'd0, ir}, {59'd0, 5'h01});

    // Five TMS=1 reach TLR and re-arm the reset opcode
    repeat (5) step(1, 0);
    chk("ir_tms_reset", {59'd0, ir}, {59'd0, IR_RST_EXP});
    step(0, 0);

    // Port disable mid-SHIFT_DR
    cap_data = 32'hA5A5_0F0F;
    load_ir(5'h11);
    repeat (4) exp_tdo_q.push_back(1'b1);
    step(1, 0); step(0, 0); step(0, 0);
    repeat (3) step(0, 1);
    @(negedge tclk);
    tap_en = 1'b0; tms = 1'b0;
    @(posedge tclk);
    #1;
    chk("tap_en_tdo_en", {63'd0, tdo_en}, 64'd0);
    step(0, 0);
    chk("tap_en_ir", {59'd0, ir}, {59'd0, IR_RST_EXP});
    tap_en = 1'b1;
    step(0, 0);

    // trst mid-shift discards everything, no strobe
    load_ir(5'h11);
    exp_tdo_q.push_back(1'b1);
    exp_tdo_q.push_back(1'b1);
    step(1, 0); step(0, 0); step(0, 0);
    step(0, 0); step(0, 0);
    #1 trst = 1'b1;
    #1;
    chk("trst_tdo_en", {63'd0, tdo_en},  64'd0);
    chk("trst_ir",     {59'd0, ir},      {59'd0, IR_RST_EXP});
    chk("trst_dr",     {32'd0, dr_data}, 64'd0);
    chk("trst_update", {63'd0, dr_upd},  64'd0);
    @(negedge tclk);
    trst = 1'b0;
    step(0, 0);
    repeat (3) step(1, 0);

    chk("tdo_queue_drained", 64'(exp_tdo_q.size()), 64'd0);
    chk("upd_queue_drained", 64'(exp_upd_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
